// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hc_state_t    : controller FSM states (RUN, MEM_WAIT)
//   REG_X0        : architectural zero register index
//   DEFAULT_CNT_W : default width of the performance counters
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hc_state_t;

    localparam logic [4:0]  REG_X0        = 5'd0;
    localparam int unsigned DEFAULT_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   clr   : synchronous clear, dominates inc
//   inc   : increment by one unless already all-ones
//   count : current value
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline.
// Resolves load-use hazards (one bubble), taken branches (squash IF/ID and ID/EX)
// and multi-cycle data-memory accesses (freeze until mem_ready).
//   clk, rst            : clock, synchronous active-low reset
//   id_rs1/id_rs2       : ID source registers, id_use_rs1/id_use_rs2 qualify them
//   ex_rd, ex_mem_r     : EX destination register, EX holds a load
//   ex_br_taken         : EX resolved a taken branch/jump
//   mem_req, mem_ready  : MEM data access request and completion
//   pc_en .. exmem_en   : pipeline register write enables
//   ifid_flush/idex_flush: load NOP into IF/ID, ID/EX
//   mem_timeout         : sticky, an access exceeded MEM_TO wait cycles
//   stall_cycles        : saturating count of frozen/bubbled cycles
//   flush_count         : saturating count of branch flush cycles
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = DEFAULT_CNT_W,
    parameter int unsigned MEM_TO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_r,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Wait counter saturates at MEM_TO, so it needs to represent MEM_TO itself.
    localparam int unsigned     WAIT_W    = $clog2(MEM_TO + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TO);

    hc_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic load_use;
    logic freeze;
    logic stall_inc;
    logic flush_inc;

    assign load_use = ex_mem_r && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // In MEM_WAIT the access is already outstanding, so mem_req is not needed.
    assign freeze = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    assign stall_inc = rst && (freeze || (load_use && !ex_br_taken));
    assign flush_inc = rst && !freeze && ex_br_taken;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                // The MEM_TO-th wait cycle sets the flag; waiting continues regardless.
                if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                end
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (mem_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Priority: reset, memory freeze, branch flush, load-use bubble.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (!rst),
        .inc  (stall_inc),
        .count(stall_cycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .clr  (!rst),
        .inc  (flush_inc),
        .count(flush_count)
    );

endmodule
